// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and config-legality check for the multi-channel divider
package clk_div_pkg;

    localparam int CLK_DIV_MIN_PERIOD   = 2;
    localparam int CLK_DIV_RESET_PERIOD = 50;
    localparam int CLK_DIV_RESET_HIGH   = 25;
    localparam int CLK_DIV_FN_W         = 32;

    // Callers zero-extend their DIV_W-bit fields to CLK_DIV_FN_W bits.
    function automatic logic cfg_legal(input logic [CLK_DIV_FN_W-1:0] period,
                                       input logic [CLK_DIV_FN_W-1:0] high);
        return (period >= CLK_DIV_FN_W'(CLK_DIV_MIN_PERIOD)) && (high != '0) && (high < period);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: active/shadow settings, counter, registered outputs
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W        = 16,
    parameter int RESET_PERIOD = CLK_DIV_RESET_PERIOD,
    parameter int RESET_HIGH   = CLK_DIV_RESET_HIGH
) (
    input  logic             clk_in,
    input  logic             rst_a_n,
    input  logic             en,
    input  logic             load,
    input  logic [DIV_W-1:0] load_period,
    input  logic [DIV_W-1:0] load_high,
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);

    logic [DIV_W-1:0] period_q, period_d;
    logic [DIV_W-1:0] high_q, high_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] shadow_p_q, shadow_p_d;
    logic [DIV_W-1:0] shadow_h_q, shadow_h_d;
    logic             pending_q, pending_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic [DIV_W-1:0] cnt_next;
    logic [DIV_W-1:0] high_eff;
    logic             wrap;

    assign wrap = (cnt_q == period_q - DIV_W'(1));

    always_comb begin
        period_d   = period_q;
        high_d     = high_q;
        cnt_d      = cnt_q;
        shadow_p_d = shadow_p_q;
        shadow_h_d = shadow_h_q;
        pending_d  = pending_q;
        clk_d      = 1'b0;
        tick_d     = 1'b0;
        cnt_next   = cnt_q + DIV_W'(1);
        high_eff   = high_q;

        if (en) begin
            if (wrap) begin
                cnt_next = '0;
                // New settings take effect exactly at the period boundary.
                if (pending_q) begin
                    period_d  = shadow_p_q;
                    high_d    = shadow_h_q;
                    high_eff  = shadow_h_q;
                    pending_d = 1'b0;
                end
            end
            cnt_d  = cnt_next;
            clk_d  = (cnt_next < high_eff);
            tick_d = (cnt_next == '0);
        end else begin
            cnt_d = period_q - DIV_W'(1);
            if (pending_q) begin
                period_d  = shadow_p_q;
                high_d    = shadow_h_q;
                cnt_d     = shadow_p_q - DIV_W'(1);
                pending_d = 1'b0;
            end
        end

        // A load is only accepted while nothing is pending, so it never races an apply.
        if (load) begin
            shadow_p_d = load_period;
            shadow_h_d = load_high;
            pending_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_a_n) begin
        if (!rst_a_n) begin
            period_q   <= DIV_W'(RESET_PERIOD);
            high_q     <= DIV_W'(RESET_HIGH);
            cnt_q      <= DIV_W'(RESET_PERIOD - 1);
            shadow_p_q <= DIV_W'(RESET_PERIOD);
            shadow_h_q <= DIV_W'(RESET_HIGH);
            pending_q  <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            period_q   <= period_d;
            high_q     <= high_d;
            cnt_q      <= cnt_d;
            shadow_p_q <= shadow_p_d;
            shadow_h_q <= shadow_h_d;
            pending_q  <= pending_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
        end
    end

    assign pending = pending_q;
    assign clk_out = clk_q;
    assign tick    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock/tick generator with valid/ready config port
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int DIV_W        = 16,
    parameter int RESET_PERIOD = CLK_DIV_RESET_PERIOD,
    parameter int RESET_HIGH   = CLK_DIV_RESET_HIGH,
    localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_in,
    input  logic                rst_a_n,
    input  logic [CHANNELS-1:0] en,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [DIV_W-1:0]    cfg_period,
    input  logic [DIV_W-1:0]    cfg_high,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);

    logic [CHANNELS-1:0] ch_sel;
    logic [CHANNELS-1:0] pend;
    logic [CHANNELS-1:0] load;
    logic                xfer;
    logic                legal;
    logic                cfg_err_q, cfg_err_d;

    // A channel index beyond CHANNELS matches no select line and is rejected as illegal.
    assign cfg_ready = ~|(ch_sel & pend);
    assign xfer      = cfg_valid & cfg_ready;
    assign legal     = cfg_legal(CLK_DIV_FN_W'(cfg_period), CLK_DIV_FN_W'(cfg_high)) & (|ch_sel);
    assign cfg_err_d = xfer & ~legal;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign ch_sel[g] = (cfg_ch == CH_W'(g));
        assign load[g]   = xfer & legal & ch_sel[g];

        clk_div_chan #(
            .DIV_W        (DIV_W),
            .RESET_PERIOD (RESET_PERIOD),
            .RESET_HIGH   (RESET_HIGH)
        ) u_chan (
            .clk_in      (clk_in),
            .rst_a_n     (rst_a_n),
            .en          (en[g]),
            .load        (load[g]),
            .load_period (cfg_period),
            .load_high   (cfg_high),
            .pending     (pend[g]),
            .clk_out     (clk_out[g]),
            .tick        (tick[g])
        );
    end

    always_ff @(posedge clk_in or negedge rst_a_n) begin
        if (!rst_a_n) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - directed self-checking bench for clk_div_multi
module tb_clk_div_multi;
    import clk_div_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_a_n;
    logic [3:0]  en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_period;
    logic [15:0] cfg_high;
    logic        cfg_err;
    logic [3:0]  clk_out;
    logic [3:0]  tick;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0     = 0;

    always #5 clk_in = ~clk_in;

    clk_div_multi dut (
        .clk_in     (clk_in),
        .rst_a_n    (rst_a_n),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_err    (cfg_err),
        .clk_out    (clk_out),
        .tick       (tick)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
        cyc++;
    endtask

    task automatic cfg(input int ch, input int p, input int h);
        int waited = 0;
        cfg_ch     = 2'(ch);
        cfg_period = 16'(p);
        cfg_high   = 16'(h);
        cfg_valid  = 1'b1;
        #1;
        while (!cfg_ready && waited < 100) begin
            step();
            #1;
            waited++;
        end
        check("cfg_wait_bound", 32'(waited < 100), 32'd1);
        step();
        cfg_valid = 1'b0;
    endtask

    function automatic logic [3:0] exp_clk3(int k);
        return {(k % 3) < 2, (k % 5) < 2, (k % 4) < 1, 1'b0};
    endfunction

    function automatic logic [3:0] exp_tick3(int k);
        return {(k % 3) == 0, (k % 5) == 0, (k % 4) == 0, 1'b0};
    endfunction

    function automatic logic exp_clk5(int k);
        if (k < 10)      return (k % 10) < 5;
        else if (k < 16) return ((k - 10) % 6) < 3;
        else if (k < 32) return ((k - 16) % 8) < 4;
        else             return ((k - 32) % 4) < 2;
    endfunction

    function automatic logic exp_tick5(int k);
        if (k < 10)      return k == 0;
        else if (k < 16) return ((k - 10) % 6) == 0;
        else if (k < 32) return ((k - 16) % 8) == 0;
        else             return ((k - 32) % 4) == 0;
    endfunction

    function automatic logic exp_ready5(int k);
        return !((k >= 3 && k <= 9) || (k >= 11 && k <= 15) || (k >= 24 && k <= 31));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst_a_n = 1'b0; en = 4'b0; cfg_valid = 1'b0;
        cfg_ch = 2'd0; cfg_period = 16'd0; cfg_high = 16'd0;
        step(); step();
        rst_a_n = 1'b1;
        #1;
        check("rst_clk", 32'(clk_out), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_err", 32'(cfg_err), 32'h0);
        check("rst_ready", 32'(cfg_ready), 32'h1);
        step(); step();
        check("idle_clk", 32'(clk_out), 32'h0);

        // Reset defaults on ch0: period 50, high 25.
        en[0] = 1'b1;
        step();
        for (int k = 0; k < 105; k++) begin
            check($sformatf("t1_clk k=%0d", k), 32'(clk_out), 32'((k % 50) < 25));
            check($sformatf("t1_tick k=%0d", k), 32'(tick), 32'((k % 50) == 0));
            step();
        end
        check("t1_mid_high", 32'(clk_out[0]), 32'h1);
        en[0] = 1'b0;
        step();
        check("t1_dis_clk", 32'(clk_out), 32'h0);
        check("t1_dis_tick", 32'(tick), 32'h0);

        // ch1 P=4 H=1 loaded while disabled.
        cfg(1, 4, 1);
        check("t2_err", 32'(cfg_err), 32'h0);
        check("t2_ready_drop", 32'(cfg_ready), 32'h0);
        step();
        check("t2_ready_rise", 32'(cfg_ready), 32'h1);
        en[1] = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t2_clk k=%0d", k), 32'(clk_out), 32'({2'b00, (k % 4) == 0, 1'b0}));
            check($sformatf("t2_tick k=%0d", k), 32'(tick), 32'({2'b00, (k % 4) == 0, 1'b0}));
            step();
        end
        en[1] = 1'b0;

        // ch2 P=5 H=2, ch3 P=3 H=2, ch1 P=4 H=1 in parallel.
        cfg(2, 5, 2);
        cfg(3, 3, 2);
        step();
        en = 4'b1110;
        step();
        t0 = cyc;
        for (int k = 0; k < 15; k++) begin
            check($sformatf("t3_clk k=%0d", k), 32'(clk_out), 32'(exp_clk3(k)));
            check($sformatf("t3_tick k=%0d", k), 32'(tick), 32'(exp_tick3(k)));
            step();
        end

        // Illegal requests on running ch3.
        for (int i = 0; i < 3; i++) begin
            int p;
            int h;
            p = (i == 0) ? 1 : 6;
            h = (i == 0) ? 1 : ((i == 1) ? 0 : 6);
            cfg(3, p, h);
            check($sformatf("t4_err_pulse i=%0d", i), 32'(cfg_err), 32'(!cfg_legal(32'(p), 32'(h))));
            check($sformatf("t4_err_hand i=%0d", i), 32'(cfg_err), 32'h1);
            check($sformatf("t4_ready i=%0d", i), 32'(cfg_ready), 32'h1);
            check($sformatf("t4_clk_a i=%0d", i), 32'(clk_out), 32'(exp_clk3(cyc - t0)));
            step();
            check($sformatf("t4_err_clr i=%0d", i), 32'(cfg_err), 32'h0);
            check($sformatf("t4_clk_b i=%0d", i), 32'(clk_out), 32'(exp_clk3(cyc - t0)));
        end
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t4_run_clk k=%0d", k), 32'(clk_out), 32'(exp_clk3(cyc - t0)));
            check($sformatf("t4_run_tick k=%0d", k), 32'(tick), 32'(exp_tick3(cyc - t0)));
            step();
        end

        // Mid-period reconfiguration of ch0.
        cfg(0, 10, 5);
        step();
        check("t5_ready0", 32'(cfg_ready), 32'h1);
        en[0] = 1'b1;
        step();
        for (int k = 0; k <= 40; k++) begin
            check($sformatf("t5_clk k=%0d", k), 32'(clk_out[0]), 32'(exp_clk5(k)));
            check($sformatf("t5_tick k=%0d", k), 32'(tick[0]), 32'(exp_tick5(k)));
            check($sformatf("t5_ready k=%0d", k), 32'(cfg_ready), 32'(exp_ready5(k)));
            check($sformatf("t5_err k=%0d", k), 32'(cfg_err), 32'h0);
            cfg_ch = 2'd0;
            case (k)
                2:  begin cfg_valid = 1'b1; cfg_period = 16'd6; cfg_high = 16'd3; end
                3:  begin cfg_period = 16'd8; cfg_high = 16'd4; end
                11: cfg_valid = 1'b0;
                23: begin cfg_valid = 1'b1; cfg_period = 16'd4; cfg_high = 16'd2; end
                24: cfg_valid = 1'b0;
                40: begin cfg_valid = 1'b1; cfg_period = 16'd20; cfg_high = 16'd10; end
                default: ;
            endcase
            step();
        end
        cfg_valid = 1'b0;
        #1;
        check("t6_pend_ready", 32'(cfg_ready), 32'h0);
        check("t6_pre_clk", 32'(clk_out[0]), 32'h1);

        // Asynchronous reset mid-cycle while ch0 has a pending request.
        #1;
        rst_a_n = 1'b0;
        #1;
        check("t6_rst_clk", 32'(clk_out), 32'h0);
        check("t6_rst_tick", 32'(tick), 32'h0);
        check("t6_rst_err", 32'(cfg_err), 32'h0);
        check("t6_rst_ready", 32'(cfg_ready), 32'h1);
        @(negedge clk_in);
        rst_a_n = 1'b1;
        step();
        for (int k = 0; k < 60; k++) begin
            check($sformatf("t6_clk k=%0d", k), 32'(clk_out), ((k % 50) < 25) ? 32'hF : 32'h0);
            check($sformatf("t6_tick k=%0d", k), 32'(tick), ((k % 50) == 0) ? 32'hF : 32'h0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
